// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter serialising per-requester JK commands onto one shared JK bank
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        jk,
  input  logic [IDXW*NREQ-1:0]     idx,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     err,
  output logic                     busy,
  output logic [NBITS-1:0]         q
);
  localparam int RW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, APPLY, DONE} st_t;
  st_t st_q, st_d;
  logic [RW-1:0] win_q, win_d, rr_q, rr_d, gnt_id_q, gnt_id_d, pick;
  logic [1:0] jk_q, jk_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NBITS-1:0] q_q, q_d, m;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic err_q, err_d;
  int sel, c;
  always_comb begin
    sel = -1;
    c = 0;
    // scan downward so the requester closest to rr_q (smallest offset) wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = int'(rr_q) + k;
      c = c >= NREQ ? c - NREQ : c;
      if (req[c]) sel = c;
    end
    pick = RW'(sel < 0 ? 0 : sel);
    st_d = st_q;
    win_d = win_q;
    jk_d = jk_q;
    idx_d = idx_q;
    rr_d = rr_q;
    gnt_id_d = gnt_id_q;
    // an out-of-range index shifts the bit out, leaving an empty mask and q untouched
    m = NBITS'(1) << idx_q;
    gnt_d = st_q == APPLY ? NREQ'(1) << win_q : '0;
    err_d = st_q == APPLY && int'(idx_q) >= NBITS;
    q_d = st_q != APPLY ? q_q : jk_q == 2'b01 ? q_q & ~m : jk_q == 2'b10 ? q_q | m :
          jk_q == 2'b11 ? q_q ^ m : q_q;
    if (st_q == IDLE && sel >= 0) begin
      st_d = APPLY;
      win_d = pick;
      jk_d = jk[2*sel +: 2];
      idx_d = idx[IDXW*sel +: IDXW];
    end
    if (st_q == APPLY) begin
      st_d = DONE;
      gnt_id_d = win_q;
    end
    if (st_q == DONE) begin
      st_d = IDLE;
      rr_d = win_q == RW'(NREQ - 1) ? '0 : win_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= IDLE;
      win_q <= '0;
      jk_q <= '0;
      idx_q <= '0;
      rr_q <= '0;
      gnt_id_q <= '0;
      q_q <= '0;
      gnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      win_q <= win_d;
      jk_q <= jk_d;
      idx_q <= idx_d;
      rr_q <= rr_d;
      gnt_id_q <= gnt_id_d;
      q_q <= q_d;
      gnt_q <= gnt_d;
      err_q <= err_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_id = gnt_id_q;
  assign err = err_q;
  assign busy = st_q != IDLE;
  assign q = q_q;
endmodule
